// File: rtl/sliding_window_3x3_gen.sv
// Raster-to-window generator: turns a one-pixel-per-cycle raster stream into packed 3x3
// neighbourhoods, using two line buffers for the previous rows and a 3x3 shift register.
module sliding_window_3x3_gen #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9 * PIXEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pixel_in_valid,
    input  logic [PIXEL_WIDTH-1:0]  pixel_in,
    input  logic                    pixel_in_sof,
    output logic [WINDOW_WIDTH-1:0] window_out,
    output logic                    window_out_valid,
    output logic                    frame_done
);
    // Handshake: pixel_in_valid alone qualifies a transfer (no ready, no backpressure);
    // window_out_valid and frame_done are single-cycle strobes with no downstream stall.

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;

    logic [PIXEL_WIDTH-1:0] lb_a [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb_b [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] win  [3][3];

    logic                   accept;
    logic [COL_W-1:0]       cur_col;
    logic [ROW_W-1:0]       cur_row;
    logic                   col_last;
    logic                   row_last;
    logic [PIXEL_WIDTH-1:0] tap_a;
    logic [PIXEL_WIDTH-1:0] tap_b;

    // An accepted SOF pixel is treated as (0,0) for counters and line-buffer addressing alike.
    assign accept   = pixel_in_valid;
    assign cur_col  = pixel_in_sof ? '0 : col;
    assign cur_row  = pixel_in_sof ? '0 : row;
    assign col_last = (cur_col == COL_LAST);
    assign row_last = (cur_row == ROW_LAST);
    assign tap_a    = lb_a[cur_col];
    assign tap_b    = lb_b[cur_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : cur_row + ROW_W'(1);
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FILL;
            window_out_valid <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            window_out_valid <= 1'b0;
            frame_done       <= 1'b0;
            if (accept) begin
                if (pixel_in_sof) begin
                    state <= FILL;
                end else begin
                    window_out_valid <= (state == ACTIVE) && (col >= COL_TWO);
                    if (col_last && row_last) begin
                        state      <= FILL;
                        frame_done <= 1'b1;
                    end else if (col_last && (row == ROW_ONE)) begin
                        state <= ACTIVE;
                    end
                end
            end
        end
    end

    // Line buffers are never reset: every entry is rewritten in rows 0 and 1 before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_a[cur_col] <= tap_b;
            lb_b[cur_col] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int wr = 0; wr < 3; wr++) begin
                for (int wc = 0; wc < 3; wc++) begin
                    win[wr][wc] <= '0;
                end
            end
        end else if (accept) begin
            for (int wr = 0; wr < 3; wr++) begin
                win[wr][0] <= win[wr][1];
                win[wr][1] <= win[wr][2];
            end
            win[0][2] <= tap_a;
            win[1][2] <= tap_b;
            win[2][2] <= pixel_in;
        end
    end

    always_comb begin
        window_out = '0;
        for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
                window_out[(3 * wr + wc) * PIXEL_WIDTH +: PIXEL_WIDTH] = win[wr][wc];
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_3x3_gen.sv
// Bench for sliding_window_3x3_gen: a 4x4 instance checked cycle-by-cycle against an image-array
// model, a fixed vector table, and a 512x4 instance checked against a software window extraction.
module tb_sliding_window_3x3_gen;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int WIDE = 512;

    typedef struct {
        logic        valid;
        logic [7:0]  pix;
        logic        sof;
        logic        exp_valid;
        logic [71:0] exp_win;
        logic        exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix = '0;
    logic        pix_sof = 1'b0;
    logic [71:0] wout;
    logic        wvalid;
    logic        fdone;

    logic        w_valid = 1'b0;
    logic [7:0]  w_pix = '0;
    logic        w_sof = 1'b0;
    logic [71:0] w_wout;
    logic        w_wvalid;
    logic        w_fdone;

    int n_tests = 0;
    int n_fail  = 0;
    int n_win   = 0;
    int n_done  = 0;
    int w_seen  = 0;
    int w_done  = 0;

    logic [71:0] got_q[$];
    logic [71:0] exp_q[$];
    vec_t        tbl[16];

    sliding_window_3x3_gen #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8), .WINDOW_WIDTH(72)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in_valid(pix_valid), .pixel_in(pix),
        .pixel_in_sof(pix_sof), .window_out(wout), .window_out_valid(wvalid), .frame_done(fdone)
    );

    sliding_window_3x3_gen #(
        .IMAGE_WIDTH(WIDE), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8), .WINDOW_WIDTH(72)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .pixel_in_valid(w_valid), .pixel_in(w_pix),
        .pixel_in_sof(w_sof), .window_out(w_wout), .window_out_valid(w_wvalid), .frame_done(w_fdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] p, input logic s);
        @(negedge clk);
        pix_valid = v;
        pix       = p;
        pix_sof   = s;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    // Raster pixels base+16*r+c; gaps carry random data and random (ignored) SOF.
    task automatic send_pixels(input logic first_sof, input logic [7:0] base, input int npix,
                               input bit gaps);
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
            end
            drive(1'b1, base + 8'(16 * (i / W) + (i % W)), first_sof && (i == 0));
        end
    endtask

    task automatic run_table(input logic first_sof);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].valid, tbl[i].pix, (i == 0) ? first_sof : tbl[i].sof);
            @(posedge clk);
            #1;
            check($sformatf("tbl[%0d].valid", i), 72'(wvalid), 72'(tbl[i].exp_valid));
            check($sformatf("tbl[%0d].done", i), 72'(fdone), 72'(tbl[i].exp_done));
            if (tbl[i].exp_valid) check($sformatf("tbl[%0d].window", i), wout, tbl[i].exp_win);
        end
    endtask

    // Reference model: keeps the current frame as a 2D image and cuts windows out of it.
    int         m_r = 0;
    int         m_c = 0;
    logic [7:0] img [H][W];

    always @(posedge clk) begin
        logic        e_valid;
        logic        e_done;
        logic [71:0] e_win;
        logic        in_rst;
        in_rst  = !rst_n;
        e_valid = 1'b0;
        e_done  = 1'b0;
        e_win   = '0;
        if (in_rst) begin
            m_r = 0;
            m_c = 0;
        end else if (pix_valid) begin
            if (pix_sof) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = pix;
            if (m_r >= 2 && m_c >= 2) begin
                e_valid = 1'b1;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        e_win[(3 * wr + wc) * 8 +: 8] = img[m_r - 2 + wr][m_c - 2 + wc];
            end
            e_done = (m_r == H - 1) && (m_c == W - 1);
            m_c++;
            if (m_c == W) begin
                m_c = 0;
                m_r = (m_r == H - 1) ? 0 : m_r + 1;
            end
        end
        #1;
        check("mon.valid", 72'(wvalid), 72'(e_valid));
        check("mon.done", 72'(fdone), 72'(e_done));
        if (e_valid) check("mon.window", wout, e_win);
        if (in_rst) check("mon.reset_window", wout, 72'h0);
        if (wvalid) begin
            n_win++;
            got_q.push_back(wout);
        end
        if (fdone) n_done++;
    end

    always @(posedge clk) begin
        #1;
        if (w_wvalid) begin
            w_seen++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wide.extra_window: got %h expected no window", w_wout);
            end else begin
                check("wide.window", w_wout, exp_q.pop_front());
            end
        end
        if (w_fdone) w_done++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          win0;
        int          done0;
        logic [7:0]  wimg [H][WIDE];
        logic [71:0] w;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 8'(16 * (i / W) + (i % W)), 1'b0, 1'b0, 72'h0, 1'b0};
        end
        tbl[10].exp_valid = 1'b1;  tbl[10].exp_win = 72'h22_21_20_12_11_10_02_01_00;
        tbl[11].exp_valid = 1'b1;  tbl[11].exp_win = 72'h23_22_21_13_12_11_03_02_01;
        tbl[14].exp_valid = 1'b1;  tbl[14].exp_win = 72'h32_31_30_22_21_20_12_11_10;
        tbl[15].exp_valid = 1'b1;  tbl[15].exp_win = 72'h33_32_31_23_22_21_13_12_11;
        tbl[15].exp_done  = 1'b1;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.window", wout, 72'h0);
        check("reset.valid", 72'(wvalid), 72'h0);
        check("reset.done", 72'(fdone), 72'h0);

        // 1: one continuous frame from the vector table
        run_table(1'b1);
        idle(2);

        // 2: same frame with random gaps, no SOF (natural wrap from the previous frame)
        win0 = n_win; done0 = n_done;
        send_pixels(1'b0, 8'h00, 16, 1'b1);
        idle(2);
        check("s2.windows", 72'(n_win - win0), 72'd4);
        check("s2.frame_done", 72'(n_done - done0), 72'd1);

        // 3: two frames back-to-back
        win0 = n_win; done0 = n_done;
        got_q.delete();
        send_pixels(1'b1, 8'h00, 16, 1'b0);
        send_pixels(1'b1, 8'h80, 16, 1'b0);
        idle(2);
        check("s3.windows", 72'(n_win - win0), 72'd8);
        check("s3.frame_done", 72'(n_done - done0), 72'd2);
        check("s3.first_win_f2", got_q[4], 72'hA2_A1_A0_92_91_90_82_81_80);

        // 4: SOF at (2,1) aborts, then a full frame
        win0 = n_win; done0 = n_done;
        send_pixels(1'b1, 8'h00, 9, 1'b0);
        send_pixels(1'b1, 8'h40, 16, 1'b0);
        idle(2);
        check("s4.windows", 72'(n_win - win0), 72'd4);
        check("s4.frame_done", 72'(n_done - done0), 72'd1);

        // 4b: SOF at (3,3), where a window and frame_done would otherwise fire
        win0 = n_win; done0 = n_done;
        send_pixels(1'b1, 8'h00, 15, 1'b0);
        send_pixels(1'b1, 8'h10, 16, 1'b1);
        idle(2);
        check("s4b.windows", 72'(n_win - win0), 72'd7);
        check("s4b.frame_done", 72'(n_done - done0), 72'd1);

        // 5: reset pulse at pixel (3,0), then the table frame without SOF
        send_pixels(1'b1, 8'h00, 12, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("s5.reset_window", wout, 72'h0);
        check("s5.reset_valid", 72'(wvalid), 72'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_table(1'b0);
        idle(2);

        // 6: wide image with random pixels against a software 3x3 extraction
        for (int r = 0; r < H; r++)
            for (int c = 0; c < WIDE; c++)
                wimg[r][c] = 8'($urandom);
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < WIDE; c++) begin
                w = '0;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        w[(3 * wr + wc) * 8 +: 8] = wimg[r - 2 + wr][c - 2 + wc];
                exp_q.push_back(w);
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < WIDE; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    @(negedge clk);
                    w_valid = 1'b0;
                end
                @(negedge clk);
                w_valid = 1'b1;
                w_pix   = wimg[r][c];
                w_sof   = (r == 0) && (c == 0);
            end
        end
        @(negedge clk);
        w_valid = 1'b0;
        w_sof   = 1'b0;
        repeat (3) @(negedge clk);
        check("wide.count", 72'(w_seen), 72'd1020);
        check("wide.frame_done", 72'(w_done), 72'd1);
        check("wide.queue_left", 72'(exp_q.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
